// File: rtl/ddr_weight_read_server.sv
// ddr_weight_read_server: turns each new 27-bit word address into one MIG DDR3 UI line read and returns the selected 16-bit word.
// Optional macro DDR_LINE_CACHE_EN keeps the last returned line so same-line requests bypass the MIG.
module ddr_weight_read_server #(
  parameter int ADDR_W     = 27,
  parameter int LINE_WORDS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          read_address,
  output logic [15:0]                ram_data_out,
  output logic                       read_data_valid,
  input  logic                       calib_done,
  output logic [ADDR_W-1:0]          app_addr,
  output logic [2:0]                 app_cmd,
  output logic                       app_en,
  input  logic                       app_rdy,
  input  logic [16*LINE_WORDS-1:0]   app_rd_data,
  input  logic                       app_rd_data_valid,
  output logic                       busy
);

  localparam int LANE_W = $clog2(LINE_WORDS);
  localparam int TAG_W  = ADDR_W - LANE_W;

  typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT_DATA, HIT} state_t;

  state_t            state;
  logic              served;
  logic [ADDR_W-1:0] req_addr;
  logic              new_req;
  logic [15:0]       rd_word;
  logic              hit;
  logic [15:0]       hit_word;

  assign app_cmd = 3'b001;
  assign new_req = !served || (read_address != req_addr);
  assign rd_word = app_rd_data[{req_addr[LANE_W-1:0], 4'b0000} +: 16];

`ifdef DDR_LINE_CACHE_EN
  logic [16*LINE_WORDS-1:0] line_dat;
  logic [TAG_W-1:0]         line_tag;
  logic                     line_vld;

  assign hit      = line_vld && (read_address[ADDR_W-1:LANE_W] == line_tag);
  assign hit_word = line_dat[{req_addr[LANE_W-1:0], 4'b0000} +: 16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_dat <= '0;
      line_tag <= '0;
      line_vld <= 1'b0;
    end else if (!calib_done) begin
      line_vld <= 1'b0;
    end else if (state == WAIT_DATA && app_rd_data_valid) begin
      line_dat <= app_rd_data;
      line_tag <= req_addr[ADDR_W-1:LANE_W];
      line_vld <= 1'b1;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_word = 16'h0000;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= INIT;
      read_data_valid <= 1'b0;
      ram_data_out    <= '0;
      app_en          <= 1'b0;
      app_addr        <= '0;
      busy            <= 1'b1;
      served          <= 1'b0;
      req_addr        <= '0;
    end else if (!calib_done) begin
      // Loss of calibration invalidates everything in flight; the request is replayed afterwards.
      state           <= INIT;
      read_data_valid <= 1'b0;
      served          <= 1'b0;
      app_en          <= 1'b0;
      busy            <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        IDLE: begin
          if (new_req) begin
            read_data_valid <= 1'b0;
            req_addr        <= read_address;
            busy            <= 1'b1;
            if (hit) begin
              state <= HIT;
            end else begin
              state    <= ISSUE;
              app_en   <= 1'b1;
              app_addr <= {read_address[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            end
          end
        end
        ISSUE: begin
          if (app_rdy) begin
            app_en <= 1'b0;
            state  <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (app_rd_data_valid) begin
            // Only flag valid if the engine still wants this address; otherwise IDLE relaunches.
            ram_data_out    <= rd_word;
            served          <= 1'b1;
            read_data_valid <= (read_address == req_addr);
            state           <= IDLE;
            busy            <= 1'b0;
          end
        end
        HIT: begin
          ram_data_out    <= hit_word;
          served          <= 1'b1;
          read_data_valid <= (read_address == req_addr);
          state           <= IDLE;
          busy            <= 1'b0;
        end
        default: begin
          state  <= INIT;
          app_en <= 1'b0;
          busy   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_weight_read_server.sv
// Bench for ddr_weight_read_server: directed scenarios plus randomized reads against an address-hash memory model.
module tb_ddr_weight_read_server;

  logic         clk = 1'b0;
  logic         reset;
  logic [26:0]  read_address;
  logic [15:0]  ram_data_out;
  logic         read_data_valid;
  logic         calib_done;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [26:0] got;
  int          en;
  bit          seen;

  ddr_weight_read_server dut (
    .clk(clk), .reset(reset), .read_address(read_address), .ram_data_out(ram_data_out),
    .read_data_valid(read_data_valid), .calib_done(calib_done), .app_addr(app_addr),
    .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory contents: every word address holds a fixed hash of itself.
  function automatic logic [15:0] word_of(input logic [26:0] a);
    logic [31:0] h;
    h = {5'd0, a} * 32'h9E3779B1;
    return h[31:16] ^ {5'd0, a[10:0]};
  endfunction

  function automatic logic [127:0] line_of(input logic [26:0] a);
    logic [127:0] l;
    for (int i = 0; i < 8; i++) l[i*16 +: 16] = word_of({a[26:3], 3'(i)});
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // MIG responder: waits for a command, stalls app_rdy, then returns one data beat.
  task automatic serve(input logic [127:0] line, input int rdy_dly, input bit chg, input logic [26:0] chg_addr,
                       output logic [26:0] addr, output int en_cyc, output bit ok);
    ok = 1'b0;
    en_cyc = 0;
    addr = '0;
    for (int n = 0; n < 100 && !app_en; n++) tick();
    if (!app_en) return;
    ok = 1'b1;
    addr = app_addr;
    for (int k = 0; k < 100 && app_en; k++) begin
      if (app_addr !== addr) addr = 'x;
      en_cyc++;
      app_rdy = (k >= rdy_dly);
      tick();
    end
    app_rdy = 1'b0;
    if (chg) read_address = chg_addr;
    app_rd_data = line;
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (app_en !== 1'b0) begin errors++; $display("FAIL reset_app_en: got %b want 0", app_en); end
    checks++; if (read_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", read_data_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    checks++; if (app_addr !== 27'd0) begin errors++; $display("FAIL reset_app_addr: got %h want 0", app_addr); end
    checks++; if (ram_data_out !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0", ram_data_out); end
    checks++; if (app_cmd !== 3'b001) begin errors++; $display("FAIL app_cmd: got %b want 001", app_cmd); end
  endtask

  task automatic test_calib();
    int bad;
    bad = 0;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (app_en || read_data_valid || !busy) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL precalib_quiet: got %0d active cycles want 0", bad); end
    calib_done = 1'b1;
    serve(128'h0007_0006_0005_0004_0003_0002_0001_0000, 0, 1'b0, 27'd0, got, en, seen);
    checks++; if (seen !== 1'b1 || got !== 27'h10) begin errors++; $display("FAIL calib_cmd: got seen=%b addr=%h want 1/10", seen, got); end
    checks++; if (en !== 1) begin errors++; $display("FAIL calib_en_cycles: got %0d want 1", en); end
    checks++; if (read_data_valid !== 1'b1 || ram_data_out !== 16'h0000) begin errors++; $display("FAIL calib_data: got v=%b d=%h want 1/0000", read_data_valid, ram_data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL calib_busy: got %b want 0", busy); end
  endtask

  task automatic test_rdy_stall();
    logic [127:0] l;
    l = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'hBEEF, 16'h2222, 16'h1111, 16'h0000};
    read_address = 27'h10B;
    serve(l, 5, 1'b0, 27'd0, got, en, seen);
    checks++; if (seen !== 1'b1 || got !== 27'h108) begin errors++; $display("FAIL stall_addr: got seen=%b addr=%h want 1/108", seen, got); end
    checks++; if (en !== 6) begin errors++; $display("FAIL stall_en_cycles: got %0d want 6", en); end
    checks++; if (read_data_valid !== 1'b1 || ram_data_out !== 16'hBEEF) begin errors++; $display("FAIL stall_data: got v=%b d=%h want 1/beef", read_data_valid, ram_data_out); end
  endtask

  task automatic test_stale();
    read_address = 27'h20;
    serve(line_of(27'h20), 0, 1'b1, 27'h21, got, en, seen);
    checks++; if (seen !== 1'b1 || got !== 27'h20) begin errors++; $display("FAIL stale_first_addr: got seen=%b addr=%h want 1/20", seen, got); end
    checks++; if (read_data_valid !== 1'b0) begin errors++; $display("FAIL stale_valid: got %b want 0", read_data_valid); end
`ifdef DDR_LINE_CACHE_EN
    tick();
    tick();
    checks++; if (app_en !== 1'b0) begin errors++; $display("FAIL stale_hit_en: got %b want 0", app_en); end
`else
    serve(line_of(27'h20), 1, 1'b0, 27'd0, got, en, seen);
    checks++; if (seen !== 1'b1 || got !== 27'h20) begin errors++; $display("FAIL stale_relaunch_addr: got seen=%b addr=%h want 1/20", seen, got); end
`endif
    checks++; if (read_data_valid !== 1'b1 || ram_data_out !== word_of(27'h21)) begin errors++; $display("FAIL stale_final: got v=%b d=%h want 1/%h", read_data_valid, ram_data_out, word_of(27'h21)); end
  endtask

  task automatic test_hold();
    int en_hi, v_lo;
    en_hi = 0;
    v_lo = 0;
    read_address = 27'h30;
    serve(line_of(27'h30), 2, 1'b0, 27'd0, got, en, seen);
    checks++; if (seen !== 1'b1 || read_data_valid !== 1'b1 || ram_data_out !== word_of(27'h30)) begin errors++; $display("FAIL hold_first: got seen=%b v=%b d=%h want 1/1/%h", seen, read_data_valid, ram_data_out, word_of(27'h30)); end
    for (int i = 0; i < 100; i++) begin
      tick();
      if (app_en) en_hi++;
      if (!read_data_valid) v_lo++;
    end
    checks++; if (en_hi !== 0) begin errors++; $display("FAIL hold_extra_cmds: got %0d app_en cycles want 0", en_hi); end
    checks++; if (v_lo !== 0) begin errors++; $display("FAIL hold_valid_drop: got %0d low cycles want 0", v_lo); end
    read_address = 27'h31;
    tick();
    checks++; if (read_data_valid !== 1'b0) begin errors++; $display("FAIL change_valid_fall: got %b want 0", read_data_valid); end
`ifdef DDR_LINE_CACHE_EN
    tick();
`else
    serve(line_of(27'h30), 0, 1'b0, 27'd0, got, en, seen);
    checks++; if (seen !== 1'b1 || got !== 27'h30) begin errors++; $display("FAIL change_addr: got seen=%b addr=%h want 1/30", seen, got); end
`endif
    checks++; if (read_data_valid !== 1'b1 || ram_data_out !== word_of(27'h31)) begin errors++; $display("FAIL change_data: got v=%b d=%h want 1/%h", read_data_valid, ram_data_out, word_of(27'h31)); end
  endtask

  task automatic test_calib_drop();
    calib_done = 1'b0;
    tick();
    checks++; if (read_data_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL drop_state: got v=%b busy=%b want 0/1", read_data_valid, busy); end
    calib_done = 1'b1;
    serve(line_of(27'h31), 0, 1'b0, 27'd0, got, en, seen);
    checks++; if (seen !== 1'b1 || got !== 27'h30) begin errors++; $display("FAIL drop_replay_addr: got seen=%b addr=%h want 1/30", seen, got); end
    checks++; if (read_data_valid !== 1'b1 || ram_data_out !== word_of(27'h31)) begin errors++; $display("FAIL drop_replay_data: got v=%b d=%h want 1/%h", read_data_valid, ram_data_out, word_of(27'h31)); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    read_address = 27'h50;
    tick();
    checks++; if (app_en !== 1'b1) begin errors++; $display("FAIL mid_issue: got app_en=%b want 1", app_en); end
    reset = 1'b1;
    #1;
    checks++; if (app_en !== 1'b0 || read_data_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_async: got en=%b v=%b busy=%b want 0/0/1", app_en, read_data_valid, busy); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    app_rd_data = line_of(27'h50);
    app_rd_data_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (read_data_valid) bad++;
    end
    app_rd_data_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL stray_beat: got %0d valid cycles want 0", bad); end
    serve(line_of(27'h50), 1, 1'b0, 27'd0, got, en, seen);
    checks++; if (seen !== 1'b1 || got !== 27'h50 || read_data_valid !== 1'b1 || ram_data_out !== word_of(27'h50)) begin errors++; $display("FAIL mid_recover: got seen=%b addr=%h v=%b d=%h want 1/50/1/%h", seen, got, read_data_valid, ram_data_out, word_of(27'h50)); end
  endtask

`ifdef DDR_LINE_CACHE_EN
  task automatic test_cache();
    read_address = 27'h40;
    serve(line_of(27'h40), 0, 1'b0, 27'd0, got, en, seen);
    checks++; if (seen !== 1'b1 || got !== 27'h40) begin errors++; $display("FAIL cache_miss_addr: got seen=%b addr=%h want 1/40", seen, got); end
    read_address = 27'h47;
    tick();
    checks++; if (read_data_valid !== 1'b0 || app_en !== 1'b0) begin errors++; $display("FAIL cache_hit_c1: got v=%b en=%b want 0/0", read_data_valid, app_en); end
    tick();
    checks++; if (read_data_valid !== 1'b1 || app_en !== 1'b0 || ram_data_out !== word_of(27'h47)) begin errors++; $display("FAIL cache_hit_c2: got v=%b en=%b d=%h want 1/0/%h", read_data_valid, app_en, ram_data_out, word_of(27'h47)); end
    read_address = 27'h48;
    serve(line_of(27'h48), 0, 1'b0, 27'd0, got, en, seen);
    checks++; if (seen !== 1'b1 || got !== 27'h48 || ram_data_out !== word_of(27'h48)) begin errors++; $display("FAIL cache_refill: got seen=%b addr=%h d=%h want 1/48/%h", seen, got, ram_data_out, word_of(27'h48)); end
  endtask
`endif

  task automatic test_random();
    logic [26:0] a, prev;
`ifdef DDR_LINE_CACHE_EN
    bit mvld;
    logic [23:0] mtag;
    mvld = 1'b0;
    mtag = '0;
`endif
    prev = read_address;
    for (int t = 0; t < 40; t++) begin
      a = 27'(32'h200 + $urandom_range(0, 31));
      if (a == prev) a = a ^ 27'd1;
      prev = a;
      read_address = a;
      tick();
      checks++; if (read_data_valid !== 1'b0) begin errors++; $display("FAIL rnd_valid_fall[%0d]: got %b want 0", t, read_data_valid); end
`ifdef DDR_LINE_CACHE_EN
      if (mvld && a[26:3] == mtag) begin
        tick();
        checks++; if (app_en !== 1'b0 || read_data_valid !== 1'b1 || ram_data_out !== word_of(a)) begin errors++; $display("FAIL rnd_hit[%0d]: got en=%b v=%b d=%h want 0/1/%h", t, app_en, read_data_valid, ram_data_out, word_of(a)); end
        continue;
      end
      mvld = 1'b1;
      mtag = a[26:3];
`endif
      serve(line_of(a), $urandom_range(0, 3), 1'b0, 27'd0, got, en, seen);
      checks++; if (seen !== 1'b1 || got !== {a[26:3], 3'b000}) begin errors++; $display("FAIL rnd_addr[%0d]: got seen=%b addr=%h want 1/%h", t, seen, got, {a[26:3], 3'b000}); end
      checks++; if (read_data_valid !== 1'b1 || ram_data_out !== word_of(a)) begin errors++; $display("FAIL rnd_data[%0d]: got v=%b d=%h want 1/%h", t, read_data_valid, ram_data_out, word_of(a)); end
    end
  endtask

  initial begin
    reset = 1'b1;
    calib_done = 1'b0;
    read_address = 27'h10;
    app_rdy = 1'b0;
    app_rd_data = '0;
    app_rd_data_valid = 1'b0;
    test_reset();
    test_calib();
    test_rdy_stall();
    test_stale();
    test_hold();
    test_calib_drop();
    test_reset_mid();
`ifdef DDR_LINE_CACHE_EN
    test_cache();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

endmodule
